// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath constants, row-state enum and signed max helper
package cnn_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_IMG_WIDTH  = 28;
  localparam int DEF_IMG_HEIGHT = 28;

  // Widest operand the max helper accepts; callers sign-extend into it.
  localparam int SMAX_W = 32;

  typedef enum logic [1:0] {
    EVEN_ROW,
    ODD_ROW,
    SKIP_ROW
  } row_state_t;

  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// rtl/pool_line_buffer.sv - simple dual-port half-row buffer of pair results, unreset storage
module pool_line_buffer #(
  parameter int DEPTH = 14,
  parameter int WIDTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pool2x2_stream.sv
// rtl/pool2x2_stream.sv - streaming 2x2 stride-2 pooling; max by default, average when POOL2X2_AVG_EN is defined
module pool2x2_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  output logic                         frame_done
);

  localparam int HALF_W = IMG_WIDTH / 2;
  localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int CW     = $clog2(IMG_WIDTH);
  localparam int RW     = $clog2(IMG_HEIGHT);
  localparam bit ODD_H  = (IMG_HEIGHT % 2) == 1;
`ifdef POOL2X2_AVG_EN
  localparam int LB_W   = DATA_WIDTH + 1;
`else
  localparam int LB_W   = DATA_WIDTH;
`endif

  row_state_t                   r_state;
  logic [CW-1:0]                r_col;
  logic [RW-1:0]                r_row;
  logic signed [DATA_WIDTH-1:0] r_h_reg;

  logic                         w_last_col;
  logic                         w_last_row;
  logic                         w_pair_col;
  logic                         w_lb_we;
  logic                         w_win_done;
  logic [AW-1:0]                w_lb_addr;
  logic signed [LB_W-1:0]       w_pair;
  logic signed [LB_W-1:0]       w_lb_rd;
  logic signed [DATA_WIDTH-1:0] w_win;

  assign w_last_col = (r_col == CW'(IMG_WIDTH - 1));
  assign w_last_row = (r_row == RW'(IMG_HEIGHT - 1));
  // An odd trailing column lands on an even index, so it never forms a pair.
  assign w_pair_col = r_col[0];
  assign w_lb_addr  = AW'(r_col >> 1);
  assign w_lb_we    = valid_in && w_pair_col && (r_state == EVEN_ROW);
  assign w_win_done = valid_in && w_pair_col && (r_state == ODD_ROW);

`ifdef POOL2X2_AVG_EN
  logic signed [DATA_WIDTH+1:0] w_win_sum;
  logic signed [DATA_WIDTH+1:0] w_win_avg;

  assign w_pair    = LB_W'(r_h_reg) + LB_W'(data_in);
  assign w_win_sum = (DATA_WIDTH + 2)'(w_lb_rd) + (DATA_WIDTH + 2)'(w_pair);
  assign w_win_avg = w_win_sum >>> 2;
  assign w_win     = DATA_WIDTH'(w_win_avg);
`else
  assign w_pair = LB_W'(smax(SMAX_W'(r_h_reg), SMAX_W'(data_in)));
  assign w_win  = DATA_WIDTH'(smax(SMAX_W'(w_lb_rd), SMAX_W'(w_pair)));
`endif

  pool_line_buffer #(
    .DEPTH (HALF_W),
    .WIDTH (LB_W),
    .AW    (AW)
  ) u_line_buffer (
    .i_clk     (clk),
    .i_wr_en   (w_lb_we),
    .i_wr_addr (w_lb_addr),
    .i_wr_data (w_pair),
    .i_rd_addr (w_lb_addr),
    .o_rd_data (w_lb_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EVEN_ROW;
      r_col      <= '0;
      r_row      <= '0;
      r_h_reg    <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (!w_pair_col) begin
          r_h_reg <= data_in;
        end
        if (w_win_done) begin
          data_out  <= w_win;
          valid_out <= 1'b1;
        end
        if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row      <= '0;
            r_state    <= EVEN_ROW;
            frame_done <= 1'b1;
          end else begin
            r_row <= r_row + RW'(1);
            case (r_state)
              EVEN_ROW: r_state <= ODD_ROW;
              ODD_ROW:  r_state <= (ODD_H && (r_row == RW'(IMG_HEIGHT - 2))) ? SKIP_ROW : EVEN_ROW;
              default:  r_state <= EVEN_ROW;
            endcase
          end
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// tb/tb_pool2x2_stream.sv - scoreboard bench for pool2x2_stream on 4x4 and 5x5 frames
module tb_pool2x2_stream;

  logic               clk;
  logic               rst;
  logic               vin0, vin1;
  logic signed [15:0] din0, din1;
  logic signed [15:0] do0, do1;
  logic               vo0, vo1;
  logic               fd0, fd1;

  logic [1:0]         drv_win, drv_last;
  logic [1:0]         exp_vo, exp_fd;
  int                 q0[$];
  int                 q1[$];
  int                 img[0:24];
  int                 last_out[2];
  int                 n_chk;
  int                 n_err;

  pool2x2_stream #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut4 (
    .clk(clk), .rst(rst), .valid_in(vin0), .data_in(din0),
    .data_out(do0), .valid_out(vo0), .frame_done(fd0)
  );

  pool2x2_stream #(.DATA_WIDTH(16), .IMG_WIDTH(5), .IMG_HEIGHT(5)) u_dut5 (
    .clk(clk), .rst(rst), .valid_in(vin1), .data_in(din1),
    .data_out(do1), .valid_out(vo1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference window value straight from the stored frame.
  function automatic int pool_win(input int r, input int c, input int w);
    int a, b, e, d, m;
    a = img[(r-1)*w + c-1];
    b = img[(r-1)*w + c];
    e = img[r*w + c-1];
    d = img[r*w + c];
`ifdef POOL2X2_AVG_EN
    m = (a + b + e + d) >>> 2;
`else
    m = a;
    if (b > m) m = b;
    if (e > m) m = e;
    if (d > m) m = d;
`endif
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_vo <= 2'b00;
      exp_fd <= 2'b00;
    end else begin
      exp_vo <= drv_win;
      exp_fd <= drv_last;
    end
  end

  task automatic mon(input int sel, input logic vo, input logic fd, input logic signed [15:0] dout);
    int e;
    if (rst) begin
      check("rst_dout", dout, 0);
      check("rst_vout", vo, 0);
      check("rst_fdone", fd, 0);
      last_out[sel] = 0;
      if (sel == 0) q0.delete(); else q1.delete();
    end else begin
      if (vo || exp_vo[sel]) check("vout_timing", vo, exp_vo[sel]);
      if (fd || exp_fd[sel]) check("frame_done", fd, exp_fd[sel]);
      if (vo) begin
        if ((sel == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          check("extra_out", 1, 0);
        end else begin
          e = (sel == 0) ? q0.pop_front() : q1.pop_front();
          check("data_out", dout, e);
        end
        last_out[sel] = dout;
      end else begin
        check("data_hold", dout, last_out[sel]);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, vo0, fd0, do0);
    mon(1, vo1, fd1, do1);
  end

  task automatic drive(input int sel, input logic v, input int pix, input logic win, input logic last);
    @(posedge clk);
    #1;
    if (sel == 0) begin
      vin0 = v;
      din0 = 16'(pix);
    end else begin
      vin1 = v;
      din1 = 16'(pix);
    end
    drv_win[sel]  = win;
    drv_last[sel] = last;
  endtask

  task automatic idle(input int sel, input int n);
    repeat (n) drive(sel, 1'b0, int'($urandom), 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int sel, input int w, input int h, input int maxgap, input int npix);
    int r, c, g;
    logic win;
    for (int i = 0; i < npix; i++) begin
      r = i / w;
      c = i % w;
      g = int'($urandom_range(0, maxgap));
      idle(sel, g);
      win = (r % 2 == 1) && (c % 2 == 1) && (r < 2*(h/2)) && (c < 2*(w/2));
      if (win) begin
        if (sel == 0) q0.push_back(pool_win(r, c, w));
        else q1.push_back(pool_win(r, c, w));
      end
      drive(sel, 1'b1, img[i], win, i == w*h - 1);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    vin0 = 1'b0; vin1 = 1'b0;
    din0 = '0;   din1 = '0;
    drv_win = '0; drv_last = '0;
    last_out[0] = 0; last_out[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Ramp, checkerboard of -3/-7, and saturated extremes, back to back.
    for (int i = 0; i < 16; i++) img[i] = i;
    send_frame(0, 4, 4, 0, 16);
    for (int i = 0; i < 16; i++) img[i] = (((i / 4) + (i % 4)) % 2 == 0) ? -3 : -7;
    send_frame(0, 4, 4, 0, 16);
    for (int i = 0; i < 16; i++) img[i] = (((i / 4) + (i % 4)) % 2 == 0) ? 32767 : -32768;
    send_frame(0, 4, 4, 0, 16);
    for (int i = 0; i < 16; i++) img[i] = -1 - ((i % 4 == 1 && i / 4 == 1) ? 1 : 0);
    send_frame(0, 4, 4, 0, 16);
    idle(0, 3);

    for (int i = 0; i < 16; i++) img[i] = i;
    send_frame(0, 4, 4, 3, 16);
    idle(0, 3);

    // Abort a frame with reset, then a clean frame must match the ramp.
    for (int i = 0; i < 16; i++) img[i] = 100 + i;
    send_frame(0, 4, 4, 0, 6);
    idle(0, 3);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) img[i] = i;
    send_frame(0, 4, 4, 0, 16);
    idle(0, 4);

    // Odd-sized frame: trailing column and row discarded.
    for (int i = 0; i < 25; i++) img[i] = i;
    send_frame(1, 5, 5, 0, 25);
    for (int i = 0; i < 25; i++) img[i] = int'($urandom_range(0, 65535)) - 32768;
    send_frame(1, 5, 5, 2, 25);
    idle(1, 4);

    check("q4_drain", q0.size(), 0);
    check("q5_drain", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
